// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among NREQ byte producers
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-low reset
//   req_valid  bit i: requester i holds a byte
//   req_data   byte i at [8*i+7:8*i]
//   req_ready  one-cycle accept pulse to the granted requester
//   tx_start   one-cycle start pulse to uart_tx
//   tx_data    byte to transmit, stable from tx_start until tx_done
//   tx_done    one-cycle pulse from uart_tx when the stop bit completes
//   grant_id   index of the current or last granted requester
//   busy       high while a frame is in flight
//   err        one-cycle timeout pulse
//
// Optional feature: define UART_TX_TIMEOUT_EN to abandon a frame after TIMEOUT_CYC
// cycles without tx_done. Without it err is tied to 0.
module uart_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int IDW         = 2,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic [IDW-1:0]    grant_id,
   output logic              busy,
   output logic              err
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_n;
   logic [IDW-1:0] rr_ptr, gnt, nxt_ptr;
   logic gnt_found, done_ok, expire, grant, release_frame;
   int j;
   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt = '0;
      j = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (req_valid[j[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt = j[IDW-1:0];
         end
      end
   end
   // A tx_done arriving in the tx_start cycle belongs to no frame of ours.
   assign done_ok = tx_done && !tx_start;
   assign nxt_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
   assign grant = (state == IDLE) && gnt_found;
   assign release_frame = (state == WAIT) && (done_ok || expire);
   always_ff @(posedge clk)
      if (!rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (grant) state_n = WAIT;
      else if (release_frame) state_n = IDLE;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         {rr_ptr, req_ready, tx_start, tx_data, grant_id, busy} <= '0;
      end else begin
         req_ready <= '0;
         tx_start <= 1'b0;
         if (grant) begin
            tx_data <= req_data[8*gnt +: 8];
            grant_id <= gnt;
            req_ready <= NREQ'(1) << gnt;
            tx_start <= 1'b1;
            busy <= 1'b1;
         end else if (release_frame) begin
            busy <= 1'b0;
            rr_ptr <= nxt_ptr;
         end
      end
`ifdef UART_TX_TIMEOUT_EN
   logic [31:0] cnt;
   // cnt holds 0 in IDLE, so it starts from zero on every entry to WAIT.
   assign expire = (state == WAIT) && !done_ok && (cnt == 32'(TIMEOUT_CYC - 1));
   always_ff @(posedge clk)
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         err <= expire;
         cnt <= (state == IDLE) ? '0 : cnt + 32'd1;
      end
`else
   assign expire = 1'b0;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with a 10-cycle uart_tx model
module tb_uart_tx_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   logic [3:0] req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0] req_ready;
   logic tx_start, tx_done, busy, err;
   logic [7:0] tx_data;
   logic [1:0] grant_id;
   logic model_done = 1'b0, inj_done = 1'b0, model_en = 1'b1;
   int mcnt = 0;
   int passed = 0, total = 0;

   uart_tx_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .err(err)
   );

   assign tx_done = model_done | inj_done;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst) begin
         mcnt <= 0;
         model_done <= 1'b0;
      end else begin
         model_done <= 1'b0;
         if (tx_start && model_en) mcnt <= 10;
         else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) model_done <= 1'b1;
         end
      end

   task automatic wait_for(input bit sel_done, input int lim, output int n);
      n = 0;
      while (!(sel_done ? tx_done : tx_start) && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      req_valid = '0;
      inj_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 4'hF;
      req_data = 32'h13121110;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({req_ready, tx_start, tx_data, grant_id, busy, err} !== '0)
            $display("FAIL reset_outputs cyc%0d: got rdy=%b st=%b d=%h g=%0d b=%b e=%b, want all 0",
                     i, req_ready, tx_start, tx_data, grant_id, busy, err);
         else passed++;
      end
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int n;
      req_valid = 4'b0100;
      req_data = 32'h00A50000;
      @(negedge clk);
      total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else passed++;
      total++; if (tx_start !== 1'b1) $display("FAIL single_start: got %b want 1", tx_start); else passed++;
      total++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else passed++;
      total++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
      req_valid = '0;
      wait_for(1'b1, 40, n);
      total++; if (n >= 40) $display("FAIL single_done_seen: waited %0d cycles, want tx_done", n); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL single_busy_at_done: got %b want 1", busy); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy); else passed++;
      total++; if (tx_data !== 8'hA5) $display("FAIL single_data_hold: got %h want a5", tx_data); else passed++;
   endtask

   task automatic test_spurious_done();
      int n;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      total++; if ({busy, tx_start} !== 2'b00) $display("FAIL idle_done_ignored: got busy=%b start=%b want 0 0", busy, tx_start); else passed++;
      req_valid = 4'b0001;
      req_data = 32'h00000077;
      @(negedge clk);
      total++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd0, 8'h77}) $display("FAIL spur_grant: got st=%b g=%0d d=%h want 1 0 77", tx_start, grant_id, tx_data); else passed++;
      req_valid = '0;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL start_cycle_done_ignored: busy got %b want 1", busy); else passed++;
      wait_for(1'b1, 40, n);
      total++; if (n >= 40) $display("FAIL spur_done_seen: waited %0d cycles", n); else passed++;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n;
      logic [1:0] g;
      apply_reset();
      req_valid = 4'hF;
      req_data = 32'h13121110;
      for (int i = 0; i < 5; i++) begin
         g = 2'(i % 4);
         wait_for(1'b0, 50, n);
         total++; if (grant_id !== g) $display("FAIL rr_grant%0d: got %0d want %0d", i, grant_id, g); else passed++;
         total++; if (tx_data !== 8'h10 + 8'(g)) $display("FAIL rr_data%0d: got %h want %h", i, tx_data, 8'h10 + 8'(g)); else passed++;
         total++; if (req_ready !== 4'(1) << g) $display("FAIL rr_ready%0d: got %b want %b", i, req_ready, 4'(1) << g); else passed++;
         if (i > 0) begin
            total++; if (n != 2) $display("FAIL rr_gap%0d: got %0d cycles want 2", i, n); else passed++;
         end
         wait_for(1'b1, 50, n);
         total++; if (n >= 50) $display("FAIL rr_done%0d: no tx_done within %0d cycles", i, n); else passed++;
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_mid_frame();
      int n, k, bad;
      req_valid = 4'b0010;
      req_data = 32'h33001100;
      wait_for(1'b0, 5, n);
      total++; if ({grant_id, tx_data} !== {2'd1, 8'h11}) $display("FAIL mid_grant1: got g=%0d d=%h want 1 11", grant_id, tx_data); else passed++;
      req_valid = 4'b1000;
      k = 0;
      bad = 0;
      while (!tx_done && k < 50) begin
         @(negedge clk);
         k++;
         if (req_ready !== 4'b0000 || tx_data !== 8'h11) bad++;
      end
      total++; if (bad != 0 || k >= 50) $display("FAIL mid_wait_hold: got %0d bad cycles over %0d want 0", bad, k); else passed++;
      wait_for(1'b0, 10, n);
      total++; if (n != 2) $display("FAIL mid_gap: got %0d want 2", n); else passed++;
      total++; if ({grant_id, tx_data, req_ready} !== {2'd3, 8'h33, 4'b1000}) $display("FAIL mid_grant3: got g=%0d d=%h r=%b want 3 33 1000", grant_id, tx_data, req_ready); else passed++;
      req_valid = '0;
      wait_for(1'b1, 50, n);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      req_valid = 4'b0100;
      req_data = 32'h00220000;
      wait_for(1'b0, 5, n);
      req_valid = '0;
      wait_for(1'b1, 50, n);
      @(negedge clk);
      req_valid = 4'b1000;
      req_data = 32'h44000000;
      wait_for(1'b0, 5, n);
      total++; if (grant_id !== 2'd3) $display("FAIL rstmid_pre_grant: got %0d want 3", grant_id); else passed++;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if ({busy, tx_start, grant_id, tx_data} !== '0) $display("FAIL rstmid_clear: got b=%b st=%b g=%0d d=%h want 0", busy, tx_start, grant_id, tx_data); else passed++;
      @(negedge clk);
      req_valid = 4'b1001;
      req_data = 32'h55000066;
      rst = 1'b1;
      @(negedge clk);
      total++; if ({tx_start, grant_id, tx_data} !== {1'b1, 2'd0, 8'h66}) $display("FAIL rstmid_grant0: got st=%b g=%0d d=%h want 1 0 66", tx_start, grant_id, tx_data); else passed++;
      req_valid = '0;
      wait_for(1'b1, 50, n);
      total++; if (n >= 50) $display("FAIL rstmid_done: no tx_done within %0d cycles", n); else passed++;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n, k, bad;
      model_en = 1'b0;
      req_valid = 4'b0001;
      req_data = 32'h00000099;
      wait_for(1'b0, 5, n);
      req_valid = '0;
`ifdef UART_TX_TIMEOUT_EN
      k = 0;
      bad = 0;
      do begin
         @(negedge clk);
         k++;
      end while (err !== 1'b1 && k < 30);
      total++; if (k != 16) $display("FAIL timeout_delay: err after %0d cycles want 16", k); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else passed++;
      req_valid = 4'b0011;
      req_data = 32'h0000BBAA;
      @(negedge clk);
      total++; if (err !== 1'b0) $display("FAIL timeout_pulse_width: err got %b want 0", err); else passed++;
      total++; if ({tx_start, grant_id} !== {1'b1, 2'd1}) $display("FAIL timeout_next_grant: got st=%b g=%0d want 1 1", tx_start, grant_id); else passed++;
      req_valid = '0;
`else
      k = 0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         k++;
         if (busy !== 1'b1 || err !== 1'b0) bad++;
      end
      total++; if (bad != 0) $display("FAIL no_timeout_hold: got %0d bad cycles of %0d want 0", bad, k); else passed++;
`endif
      model_en = 1'b1;
      apply_reset();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_spurious_done();
      test_round_robin();
      test_mid_frame();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
